// File: rtl/sysid_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sysid_reader_pkg
// Brief    : Shared types and constants for the system-ID reader master.
// Revision : 1.0 - initial release
// ============================================================================
package sysid_reader_pkg;

    localparam int DATA_W = 32;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_ID = 3'd1,
        LAT_ID = 3'd2,
        REQ_TS = 3'd3,
        LAT_TS = 3'd4,
        FIN    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sysid_reader_timeout.sv
`default_nettype none
// ============================================================================
// Module   : sysid_reader_timeout
// Brief    : 16-bit stall counter with expire flag for the read timeout.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_reader_timeout #(
    parameter int TIMEOUT_CYCLES = 1023
)(
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [15:0] c_limit = TIMEOUT_CYCLES[15:0];

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= 16'd0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expired = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/sysid_reader_master.sv
`default_nettype none
// ============================================================================
// Module   : sysid_reader_master
// Brief    : Avalon-MM master reading system-ID and timestamp, then comparing
//            both against expected values. Define SYSID_READER_TIMEOUT_EN to
//            build the waitrequest timeout.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_reader_master
    import sysid_reader_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID        = 32'd0,
    parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1417485996,
    parameter int                READ_LATENCY       = 0,
    parameter int                TIMEOUT_CYCLES     = 1023
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic              error,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] timestamp_value
);

    localparam logic [2:0] c_read_latency = READ_LATENCY[2:0];
    localparam logic       c_no_latency   = (READ_LATENCY == 0);

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_lat;
    logic                r_match;
    logic [DATA_W-1:0]   r_id_value;
    logic [DATA_W-1:0]   r_ts_value;
    logic                w_expired;
    logic                w_req;
    logic                w_lat;
    logic                w_accept;
    logic                w_lat_hit;
    logic                w_capture;
    logic                w_start_ok;
    logic                w_match_now;

    assign w_req       = (r_state == REQ_ID) || (r_state == REQ_TS);
    assign w_lat       = (r_state == LAT_ID) || (r_state == LAT_TS);
    assign w_accept    = w_req && !w_expired && !avm_waitrequest;
    assign w_lat_hit   = (r_lat == c_read_latency);
    assign w_capture   = c_no_latency ? w_accept : (w_lat && w_lat_hit);
    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_match_now = (r_id_value == EXPECTED_ID) &&
                         (r_ts_value == EXPECTED_TIMESTAMP) && !error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = REQ_ID;
            REQ_ID: begin
                if (w_expired)     w_state_next = FIN;
                else if (w_accept) w_state_next = c_no_latency ? REQ_TS : LAT_ID;
            end
            LAT_ID:  if (w_lat_hit) w_state_next = REQ_TS;
            REQ_TS: begin
                if (w_expired)     w_state_next = FIN;
                else if (w_accept) w_state_next = c_no_latency ? FIN : LAT_TS;
            end
            LAT_TS:  if (w_lat_hit) w_state_next = FIN;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        avm_read    = 1'b0;
        avm_address = ADDR_ID;
        busy        = 1'b0;
        done        = 1'b0;
        match       = r_match;
        case (r_state)
            REQ_ID: begin
                avm_read = !w_expired;
                busy     = 1'b1;
            end
            REQ_TS: begin
                avm_read    = !w_expired;
                avm_address = ADDR_TS;
                busy        = 1'b1;
            end
            LAT_ID, LAT_TS: busy = 1'b1;
            FIN: begin
                done  = 1'b1;
                match = w_match_now;
            end
            default: ;
        endcase
    end

    // Latency count is 1 in the first cycle after acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lat      <= 3'd0;
            r_match    <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            if (w_start_ok) begin
                r_match <= 1'b0;
            end else if (r_state == FIN) begin
                r_match <= w_match_now;
            end
            if (w_accept) begin
                r_lat <= 3'd1;
            end else if (w_lat) begin
                r_lat <= w_lat_hit ? 3'd0 : r_lat + 3'd1;
            end
            if (w_capture) begin
                if ((r_state == REQ_ID) || (r_state == LAT_ID)) begin
                    r_id_value <= avm_readdata;
                end else begin
                    r_ts_value <= avm_readdata;
                end
            end
        end
    end

`ifdef SYSID_READER_TIMEOUT_EN
    logic r_error;

    sysid_reader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clock),
        .rst       (reset),
        .i_clear   (!w_req || w_accept),
        .i_enable  (w_req && avm_waitrequest),
        .o_expired (w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset || w_start_ok) begin
            r_error <= 1'b0;
        end else if (w_req && w_expired) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign w_expired = 1'b0;
    assign error     = 1'b0;
`endif

    assign id_value        = r_id_value;
    assign timestamp_value = r_ts_value;

endmodule
`default_nettype wire

// File: tb/tb_sysid_reader_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysid_reader_master
// Brief    : Scoreboard bench for sysid_reader_master (latency 0 and 2 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysid_reader_master;
    import sysid_reader_pkg::*;

    localparam logic [31:0] c_ts0 = 32'd1417485996;
    localparam logic [31:0] c_id1 = 32'h0BAD_F00D;
    localparam logic [31:0] c_ts1 = 32'h5A5A_1234;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        match;
        logic        error;
        logic        chk_data;
        logic [31:0] id;
        logic [31:0] ts;
        int          t0;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    // DUT 0: zero latency, waitrequest driven by the bench
    logic        reset0 = 1'b1, start0 = 1'b0, wait0 = 1'b0;
    logic        addr0, read0, busy0, done0, match0, error0;
    logic [31:0] rdata0, id0, ts0;
    logic [31:0] s0_id = 32'd0, s0_ts = c_ts0;
    assign rdata0 = addr0 ? s0_ts : s0_id;

    sysid_reader_master #(
        .READ_LATENCY   (0),
        .TIMEOUT_CYCLES (10)
    ) u_dut0 (
        .clock (clock), .reset (reset0), .start (start0),
        .avm_address (addr0), .avm_read (read0),
        .avm_waitrequest (wait0), .avm_readdata (rdata0),
        .busy (busy0), .done (done0), .match (match0), .error (error0),
        .id_value (id0), .timestamp_value (ts0)
    );

    // DUT 1: two-cycle latency; slave returns junk except at acceptance+2
    logic        reset1 = 1'b1, start1 = 1'b0;
    logic        addr1, read1, busy1, done1, match1, error1;
    logic [31:0] rdata1, id1, ts1;
    logic [3:0]  s1_cnt  = 4'd0;
    logic        s1_addr = 1'b0;

    always @(posedge clock) begin
        if (read1) begin
            s1_cnt  <= 4'd1;
            s1_addr <= addr1;
        end else if (s1_cnt != 4'd0 && s1_cnt != 4'd15) begin
            s1_cnt <= s1_cnt + 4'd1;
        end
    end
    assign rdata1 = (!read1 && s1_cnt == 4'd2) ? (s1_addr ? c_ts1 : c_id1)
                                               : {28'hBAD0000, s1_cnt};

    sysid_reader_master #(
        .EXPECTED_ID        (c_id1),
        .EXPECTED_TIMESTAMP (c_ts1),
        .READ_LATENCY       (2)
    ) u_dut1 (
        .clock (clock), .reset (reset1), .start (start1),
        .avm_address (addr1), .avm_read (read1),
        .avm_waitrequest (1'b0), .avm_readdata (rdata1),
        .busy (busy1), .done (done1), .match (match1), .error (error1),
        .id_value (id1), .timestamp_value (ts1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every done pulse must match the head of its queue
    always @(negedge clock) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut0_unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                check("dut0_done_latency", cyc - e0.t0, e0.lat);
                check("dut0_match", match0, e0.match);
                check("dut0_error", error0, e0.error);
                check("dut0_busy_in_fin", busy0, 1'b0);
                if (e0.chk_data) begin
                    check("dut0_id_value", id0, e0.id);
                    check("dut0_ts_value", ts0, e0.ts);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut1_unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
            end else begin
                e1 = q1.pop_front();
                check("dut1_done_latency", cyc - e1.t0, e1.lat);
                check("dut1_match", match1, e1.match);
                check("dut1_error", error1, e1.error);
                check("dut1_id_value", id1, e1.id);
                check("dut1_ts_value", ts1, e1.ts);
            end
        end
    end

    function automatic exp_t mk(input logic m, input logic er, input logic cd,
                                input logic [31:0] id, input logic [31:0] ts, input int lat);
        exp_t x;
        x.match = m; x.error = er; x.chk_data = cd;
        x.id = id; x.ts = ts; x.t0 = 0; x.lat = lat;
        return x;
    endfunction

    // Called at a negedge; returns at the negedge of the first busy cycle.
    task automatic run_start0(input logic push, input exp_t e);
        exp_t x = e;
        x.t0 = cyc;
        if (push) q0.push_back(x);
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
    endtask

    task automatic run_start1(input logic push, input exp_t e);
        exp_t x = e;
        x.t0 = cyc;
        if (push) q1.push_back(x);
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
    endtask

    task automatic wait_done0(input int max);
        int k = 0;
        while (done0 !== 1'b1 && k < max) begin @(negedge clock); k++; end
        if (done0 !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL dut0_done_timeout: got no done within %0d cycles, expected done", max);
        end
    endtask

    task automatic wait_done1(input int max);
        int k = 0;
        while (done1 !== 1'b1 && k < max) begin @(negedge clock); k++; end
        if (done1 !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL dut1_done_timeout: got no done within %0d cycles, expected done", max);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("dut0_reset_ctrl", {busy0, done0, match0, error0, read0, addr0}, 6'd0);
        check("dut0_reset_id", id0, 32'd0);
        check("dut1_reset_ctrl", {busy1, done1, match1, error1, read1, addr1}, 6'd0);
        check("dut1_reset_ts", ts1, 32'd0);
        reset0 = 1'b0;
        reset1 = 1'b0;
        @(negedge clock);

        // Good ID/timestamp, no stalls: address 0 then 1, done on cycle 3
        run_start0(1'b1, mk(1'b1, 1'b0, 1'b1, 32'd0, c_ts0, 3));
        check("t1_req_id", {read0, addr0, busy0}, 3'b101);
        @(negedge clock);
        check("t1_req_ts", {read0, addr0, busy0}, 3'b111);
        wait_done0(5);
        @(negedge clock);
        check("t1_done_one_cycle", done0, 1'b0);
        check("t1_match_held", match0, 1'b1);

        // Wrong ID: match clears on the new start and stays 0 at done
        s0_id = 32'h1234_5678;
        run_start0(1'b1, mk(1'b0, 1'b0, 1'b1, 32'h1234_5678, c_ts0, 3));
        check("t2_match_cleared", match0, 1'b0);
        wait_done0(5);
        @(negedge clock);

        // Five stall cycles on the ID read
        s0_id = 32'd0;
        wait0 = 1'b1;
        run_start0(1'b1, mk(1'b1, 1'b0, 1'b1, 32'd0, c_ts0, 8));
        for (int i = 0; i < 6; i++) begin
            check("t3_stall_hold", {read0, addr0}, 2'b10);
            if (i == 5) wait0 = 1'b0;
            else @(negedge clock);
        end
        wait_done0(10);
        @(negedge clock);

`ifdef SYSID_READER_TIMEOUT_EN
        begin
            int hi = 0;
            wait0 = 1'b1;
            run_start0(1'b1, mk(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 12));
            for (int i = 0; i < 11; i++) begin
                if (read0 === 1'b1) hi++;
                if (i < 10) @(negedge clock);
            end
            check("t5_read_dropped", read0, 1'b0);
            check("t5_read_cycles", hi, 10);
            wait_done0(5);
            @(negedge clock);
            check("t5_error_held", {error0, match0}, 2'b10);
            wait0 = 1'b0;
        end
`else
        wait0 = 1'b1;
        run_start0(1'b0, mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0));
        repeat (40) @(negedge clock);
        check("t5_still_waiting", {busy0, read0, error0}, 3'b110);
        reset0 = 1'b1;
        @(negedge clock);
        reset0 = 1'b0;
        check("t5_reset_recovers", busy0, 1'b0);
        wait0 = 1'b0;
        @(negedge clock);
`endif
        run_start0(1'b1, mk(1'b1, 1'b0, 1'b1, 32'd0, c_ts0, 3));
        check("t5_error_cleared", error0, 1'b0);
        wait_done0(5);
        @(negedge clock);

        // Latency 2 with junk data around the capture cycle; extra start ignored
        run_start1(1'b1, mk(1'b1, 1'b0, 1'b1, c_id1, c_ts1, 7));
        check("t4_lat_id_noread", read1, 1'b1);
        @(negedge clock);
        check("t4_lat_read_low", read1, 1'b0);
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        wait_done1(12);
        @(negedge clock);
        check("t4_idle_after", busy1, 1'b0);

        // Reset during LAT_TS: everything clears, no done pulse
        run_start1(1'b0, mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0));
        repeat (4) @(negedge clock);
        check("t6_in_lat_ts", {busy1, read1, addr1}, 3'b100);
        reset1 = 1'b1;
        @(negedge clock);
        check("t6_reset_ctrl", {busy1, done1, match1, error1, read1, addr1}, 6'd0);
        check("t6_reset_id", id1, 32'd0);
        check("t6_reset_ts", ts1, 32'd0);
        reset1 = 1'b0;
        repeat (10) @(negedge clock);
        run_start1(1'b1, mk(1'b1, 1'b0, 1'b1, c_id1, c_ts1, 7));
        wait_done1(12);
        @(negedge clock);

        if (q0.size() != 0 || q1.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
